// File: rtl/rv_p4_pkg.sv
// Shared constants and state encoding for the RX-side WRR grant scheduler.
// Default sizes match the 32-port MAC RX merge path.
package rv_p4_pkg;

    localparam int NUM_PORTS = 32;
    localparam int PORT_W    = $clog2(NUM_PORTS);
    localparam int WEIGHT_W  = 4;
    localparam int WDOG_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        GRANT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/mac_rx_wrr_sched_if.sv
// Request/grant bundle between the RX port bank, the merge mux and the scheduler.
// The scheduler holds the master view; the mux/port side holds the slave view.
interface mac_rx_wrr_sched_if #(
    parameter int NUM_PORTS = rv_p4_pkg::NUM_PORTS
) ();

    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] rx_valid;
    logic [NUM_PORTS-1:0] rx_sof;
    logic                 xfer;
    logic                 xfer_eof;
    logic                 grant_vld;
    logic [PORT_W-1:0]    grant_port;

    modport master (
        input  rx_valid,
        input  rx_sof,
        input  xfer,
        input  xfer_eof,
        output grant_vld,
        output grant_port
    );

    modport slave (
        output rx_valid,
        output rx_sof,
        output xfer,
        output xfer_eof,
        input  grant_vld,
        input  grant_port
    );

endinterface

// File: rtl/mac_rx_wrr_sched_rr_pick.sv
// Combinational rotating find-first: first set request at or after ptr, wrapping
// from N-1 to 0 by explicit compare so N need not be a power of two.
module rr_pick #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    localparam int unsigned NU = N;

    int unsigned pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NU) begin
                pos = pos - NU;
            end
            if (!found && req[W'(pos)]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/mac_rx_wrr_sched.sv
// Frame-atomic weighted-round-robin grant controller for the MAC RX merge path,
// with per-port frame quotas and a mid-frame stall watchdog.
module mac_rx_wrr_sched #(
    parameter int NUM_PORTS = rv_p4_pkg::NUM_PORTS,
    parameter int WEIGHT_W  = rv_p4_pkg::WEIGHT_W,
    parameter int WDOG_W    = rv_p4_pkg::WDOG_W
) (
    input  logic                                clk,
    input  logic                                rst,
    mac_rx_wrr_sched_if.master                  bus,
    input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0]  cfg_weight,
    input  logic [WDOG_W-1:0]                   cfg_wdog,
    input  logic [NUM_PORTS-1:0]                err_clr,
    output logic                                wdog_abort,
    output logic [$clog2(NUM_PORTS)-1:0]        wdog_port,
    output logic [NUM_PORTS-1:0]                err_sticky
);

    import rv_p4_pkg::*;

    localparam int PORT_W = $clog2(NUM_PORTS);

    sched_state_t                         state_q;
    sched_state_t                         state_d;
    logic [NUM_PORTS-1:0][WEIGHT_W-1:0]   credit_q;
    logic [PORT_W-1:0]                    rr_ptr_q;
    logic [PORT_W-1:0]                    grant_port_q;
    logic [WDOG_W-1:0]                    wdog_cnt_q;

    logic [NUM_PORTS-1:0]                 req;
    logic [NUM_PORTS-1:0]                 eligible;
    logic [NUM_PORTS-1:0]                 weighted_req;
    logic [NUM_PORTS-1:0]                 abort_set;
    logic                                 pick_found;
    logic [PORT_W-1:0]                    pick_idx;
    logic                                 stall;
    logic                                 wdog_hit;
    logic                                 take_grant;
    logic                                 load_credits;
    logic                                 frame_done;
    logic                                 abort;

    function automatic logic [PORT_W-1:0] port_inc(input logic [PORT_W-1:0] p);
        if (p == PORT_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return p + PORT_W'(1);
    endfunction

    assign req = bus.rx_valid & bus.rx_sof;

    always_comb begin
        eligible     = '0;
        weighted_req = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            eligible[i]     = req[i] && (credit_q[i] != '0);
            weighted_req[i] = req[i] && (cfg_weight[i] != '0);
        end
    end

    rr_pick #(
        .N (NUM_PORTS),
        .W (PORT_W)
    ) u_rr_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign stall    = !bus.rx_valid[grant_port_q];
    assign wdog_hit = (cfg_wdog != '0) && ((wdog_cnt_q + WDOG_W'(1)) == cfg_wdog);

    always_comb begin
        state_d      = state_q;
        take_grant   = 1'b0;
        load_credits = 1'b0;
        frame_done   = 1'b0;
        abort        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    take_grant = 1'b1;
                    state_d    = GRANT;
                end else if (|weighted_req) begin
                    state_d = RELOAD;
                end
            end
            RELOAD: begin
                load_credits = 1'b1;
                state_d      = IDLE;
            end
            GRANT: begin
                // Any xfer clears the watchdog, so EOF wins over a same-cycle timeout.
                if (bus.xfer && bus.xfer_eof) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else if (!bus.xfer && stall && wdog_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        abort_set = '0;
        if (abort) begin
            abort_set[grant_port_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            rr_ptr_q     <= '0;
            grant_port_q <= '0;
            wdog_cnt_q   <= '0;
            wdog_abort   <= 1'b0;
            wdog_port    <= '0;
            err_sticky   <= '0;
        end else begin
            state_q    <= state_d;
            wdog_abort <= abort;
            err_sticky <= (err_sticky & ~err_clr) | abort_set;

            if (abort) begin
                wdog_port <= grant_port_q;
            end

            if (take_grant) begin
                grant_port_q <= pick_idx;
                wdog_cnt_q   <= '0;
            end else if (state_q == GRANT) begin
                if (bus.xfer) begin
                    wdog_cnt_q <= '0;
                end else if (stall) begin
                    wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
                end
            end

            if (load_credits) begin
                credit_q <= cfg_weight;
            end else if (frame_done) begin
                if (credit_q[grant_port_q] != '0) begin
                    credit_q[grant_port_q] <= credit_q[grant_port_q] - WEIGHT_W'(1);
                end
                // Stay on this port while it still has quota left this round.
                if (credit_q[grant_port_q] > WEIGHT_W'(1)) begin
                    rr_ptr_q <= grant_port_q;
                end else begin
                    rr_ptr_q <= port_inc(grant_port_q);
                end
            end else if (abort) begin
                credit_q[grant_port_q] <= '0;
                rr_ptr_q               <= port_inc(grant_port_q);
            end
        end
    end

    assign bus.grant_vld  = (state_q == GRANT);
    assign bus.grant_port = grant_port_q;

    abort_drops_grant: assert property (@(posedge clk) disable iff (rst)
        wdog_abort |-> !bus.grant_vld);

endmodule

// File: tb/tb_mac_rx_wrr_sched.sv
// Self-checking bench for mac_rx_wrr_sched: expected grants (port, cycles since
// previous grant) are queued per scenario and compared as grants appear.
module tb_mac_rx_wrr_sched;

    localparam int NP = 32;
    localparam int WW = 4;
    localparam int DW = 16;
    localparam int PW = 5;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NP-1:0][WW-1:0]    cfg_weight;
    logic [DW-1:0]            cfg_wdog;
    logic [NP-1:0]            err_clr;
    logic                     wdog_abort;
    logic [PW-1:0]            wdog_port;
    logic [NP-1:0]            err_sticky;

    mac_rx_wrr_sched_if #(.NUM_PORTS(NP)) bus ();

    mac_rx_wrr_sched #(
        .NUM_PORTS (NP),
        .WEIGHT_W  (WW),
        .WDOG_W    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cfg_weight (cfg_weight),
        .cfg_wdog   (cfg_wdog),
        .err_clr    (err_clr),
        .wdog_abort (wdog_abort),
        .wdog_port  (wdog_port),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int port;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.rx_valid = '0;
        bus.rx_sof   = '0;
        bus.xfer     = 1'b0;
        bus.xfer_eof = 1'b0;
        err_clr      = '0;
    endtask

    task automatic set_req(input int port, input logic on);
        bus.rx_valid[port] = on;
        bus.rx_sof[port]   = on;
    endtask

    task automatic do_reset(input logic [DW-1:0] wdog);
        clear_inputs();
        cfg_wdog = wdog;
        for (int i = 0; i < NP; i++) cfg_weight[i] = WW'(1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Watches for grants, checks each against the scoreboard, optionally ends
    // every granted frame with a single eof cell.
    task automatic run_grants(input int n, input int budget, input bit auto_eof);
        int   cyc  = 0;
        int   last = 0;
        int   got  = 0;
        exp_t e;
        while (got < n && cyc < budget) begin
            tick();
            cyc++;
            bus.xfer     = 1'b0;
            bus.xfer_eof = 1'b0;
            if (bus.grant_vld === 1'b1) begin
                got++;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL grant_unexpected: got port %0d, required no grant", bus.grant_port);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.grant_port !== PW'(e.port))
                        $display("FAIL grant_port: got %0d, required %0d", bus.grant_port, e.port);
                    else passes++;
                    checks++;
                    if ((cyc - last) !== e.gap)
                        $display("FAIL grant_gap: port %0d after %0d cycles, required %0d", e.port, cyc - last, e.gap);
                    else passes++;
                end
                last = cyc;
                if (auto_eof) begin
                    bus.xfer     = 1'b1;
                    bus.xfer_eof = 1'b1;
                end
            end
        end
        if (got < n) begin
            checks++;
            $display("FAIL grant_timeout: got %0d grants, required %0d within %0d cycles", got, n, budget);
        end else if (auto_eof) begin
            tick();
            bus.xfer     = 1'b0;
            bus.xfer_eof = 1'b0;
        end
        sb.delete();
    endtask

    task automatic test_reset;
        clear_inputs();
        cfg_wdog = '0;
        for (int i = 0; i < NP; i++) cfg_weight[i] = WW'(1);
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.grant_vld !== 1'b0) $display("FAIL reset_grant_vld: got %b, required 0", bus.grant_vld); else passes++;
        checks++; if (bus.grant_port !== '0) $display("FAIL reset_grant_port: got %0d, required 0", bus.grant_port); else passes++;
        checks++; if (wdog_abort !== 1'b0) $display("FAIL reset_wdog_abort: got %b, required 0", wdog_abort); else passes++;
        checks++; if (wdog_port !== '0) $display("FAIL reset_wdog_port: got %0d, required 0", wdog_port); else passes++;
        checks++; if (err_sticky !== '0) $display("FAIL reset_err_sticky: got %h, required 0", err_sticky); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_alt_pair;
        do_reset('0);
        set_req(3, 1'b1);
        set_req(7, 1'b1);
        sb.push_back('{3, 3}); sb.push_back('{7, 2});
        sb.push_back('{3, 4}); sb.push_back('{7, 2});
        sb.push_back('{3, 4}); sb.push_back('{7, 2});
        run_grants(6, 60, 1'b1);
        clear_inputs();
    endtask

    task automatic test_weighted;
        do_reset('0);
        cfg_weight[0] = WW'(3);
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        sb.push_back('{0, 3}); sb.push_back('{0, 2}); sb.push_back('{0, 2}); sb.push_back('{1, 2});
        sb.push_back('{0, 4}); sb.push_back('{0, 2}); sb.push_back('{0, 2}); sb.push_back('{1, 2});
        run_grants(8, 80, 1'b1);
        clear_inputs();
    endtask

    task automatic test_wrap;
        do_reset('0);
        cfg_weight[31] = WW'(2);
        set_req(2, 1'b1);
        set_req(31, 1'b1);
        sb.push_back('{2, 3}); sb.push_back('{31, 2}); sb.push_back('{31, 2}); sb.push_back('{2, 4});
        run_grants(4, 40, 1'b1);
        clear_inputs();
    endtask

    task automatic test_zero_weight;
        int g = 0;
        do_reset('0);
        cfg_weight[5] = '0;
        set_req(5, 1'b1);
        repeat (100) begin
            tick();
            if (bus.grant_vld !== 1'b0) g++;
        end
        checks++; if (g !== 0) $display("FAIL zero_weight_grants: got %0d grant cycles, required 0", g); else passes++;
        // Credits are still zero only if no reload happened, so port 6 needs the full 3 cycles.
        set_req(6, 1'b1);
        sb.push_back('{6, 3});
        run_grants(1, 10, 1'b1);
        clear_inputs();
    endtask

    task automatic test_wdog_abort;
        logic ok = 1'b1;
        do_reset(DW'(8));
        set_req(2, 1'b1);
        sb.push_back('{2, 3});
        run_grants(1, 10, 1'b0);
        bus.xfer     = 1'b1;
        bus.xfer_eof = 1'b0;
        tick();
        set_req(2, 1'b0);
        bus.xfer = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (bus.grant_vld !== 1'b1 || wdog_abort !== 1'b0) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) $display("FAIL wdog_early_abort: grant lost before 8th stall cycle, required held"); else passes++;
        err_clr[2] = 1'b1;
        tick();
        checks++; if (wdog_abort !== 1'b1) $display("FAIL wdog_abort: got %b, required 1", wdog_abort); else passes++;
        checks++; if (wdog_port !== PW'(2)) $display("FAIL wdog_port: got %0d, required 2", wdog_port); else passes++;
        checks++; if (bus.grant_vld !== 1'b0) $display("FAIL wdog_grant_drop: got %b, required 0", bus.grant_vld); else passes++;
        checks++; if (err_sticky !== NP'(32'h0000_0004)) $display("FAIL wdog_sticky_set: got %h, required 00000004", err_sticky); else passes++;
        err_clr = '0;
        tick();
        checks++; if (wdog_abort !== 1'b0) $display("FAIL wdog_pulse: got %b, required 0", wdog_abort); else passes++;
        checks++; if (err_sticky !== NP'(32'h0000_0004)) $display("FAIL wdog_sticky_hold: got %h, required 00000004", err_sticky); else passes++;
        set_req(2, 1'b1);
        sb.push_back('{2, 3});
        run_grants(1, 10, 1'b1);
        set_req(2, 1'b0);
        err_clr[2] = 1'b1;
        tick();
        err_clr = '0;
        checks++; if (err_sticky !== '0) $display("FAIL wdog_sticky_clr: got %h, required 0", err_sticky); else passes++;
        clear_inputs();
    endtask

    task automatic test_wdog_eof_race;
        logic ok = 1'b1;
        do_reset(DW'(4));
        set_req(9, 1'b1);
        sb.push_back('{9, 3});
        run_grants(1, 10, 1'b0);
        bus.xfer     = 1'b1;
        bus.xfer_eof = 1'b0;
        tick();
        set_req(9, 1'b0);
        bus.xfer = 1'b0;
        repeat (3) begin
            tick();
            if (bus.grant_vld !== 1'b1 || wdog_abort !== 1'b0) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) $display("FAIL race_stall_hold: grant lost during 3 stall cycles, required held"); else passes++;
        bus.xfer     = 1'b1;
        bus.xfer_eof = 1'b1;
        tick();
        bus.xfer     = 1'b0;
        bus.xfer_eof = 1'b0;
        checks++; if (bus.grant_vld !== 1'b0) $display("FAIL race_eof_release: got %b, required 0", bus.grant_vld); else passes++;
        checks++; if (wdog_abort !== 1'b0) $display("FAIL race_no_abort: got %b, required 0", wdog_abort); else passes++;
        checks++; if (err_sticky !== '0) $display("FAIL race_no_sticky: got %h, required 0", err_sticky); else passes++;
        tick();
        // Credit was consumed by the eof, so the re-request must wait for a reload.
        set_req(9, 1'b1);
        sb.push_back('{9, 3});
        run_grants(1, 10, 1'b1);
        clear_inputs();
    endtask

    task automatic test_mid_reset;
        do_reset(DW'(3));
        set_req(1, 1'b1);
        sb.push_back('{1, 3});
        run_grants(1, 10, 1'b0);
        set_req(1, 1'b0);
        tick();
        tick();
        tick();
        checks++; if (wdog_abort !== 1'b1) $display("FAIL mid_abort: got %b, required 1", wdog_abort); else passes++;
        checks++; if (wdog_port !== PW'(1)) $display("FAIL mid_wdog_port: got %0d, required 1", wdog_port); else passes++;
        checks++; if (err_sticky !== NP'(32'h0000_0002)) $display("FAIL mid_sticky: got %h, required 00000002", err_sticky); else passes++;
        set_req(4, 1'b1);
        sb.push_back('{4, 1});
        run_grants(1, 5, 1'b0);
        rst = 1'b1;
        tick();
        checks++; if (bus.grant_vld !== 1'b0) $display("FAIL rst_grant_vld: got %b, required 0", bus.grant_vld); else passes++;
        checks++; if (bus.grant_port !== '0) $display("FAIL rst_grant_port: got %0d, required 0", bus.grant_port); else passes++;
        checks++; if (err_sticky !== '0) $display("FAIL rst_err_sticky: got %h, required 0", err_sticky); else passes++;
        checks++; if (wdog_abort !== 1'b0) $display("FAIL rst_wdog_abort: got %b, required 0", wdog_abort); else passes++;
        rst = 1'b0;
        sb.push_back('{4, 3});
        run_grants(1, 10, 1'b1);
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_alt_pair();
        test_weighted();
        test_wrap();
        test_zero_weight();
        test_wdog_abort();
        test_wdog_eof_race();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
